// File: rtl/if_fetch_unit_if.sv
// Instruction-bus bundle between the fetch stage (master) and instruction memory (slave).
// Single outstanding request; ack may arrive in the same cycle as req.
interface if_fetch_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  ibus_req_o;
   logic [ADDR_WIDTH-1:0] ibus_addr_o;
   logic                  ibus_ack_i;
   logic [DATA_WIDTH-1:0] ibus_rdata_i;

   modport master (
      output ibus_req_o,
      output ibus_addr_o,
      input  ibus_ack_i,
      input  ibus_rdata_i
   );

   modport slave (
      input  ibus_req_o,
      input  ibus_addr_o,
      output ibus_ack_i,
      output ibus_rdata_i
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding bus fetches and presents
// {pc, inst, valid} to IF_ID. A fetch in flight during a jump is drained and its data dropped.
module if_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [5:0]            stall_i,
   input  logic                  flush_jump_i,
   input  logic [ADDR_WIDTH-1:0] new_pc_i,
   if_fetch_unit_if.master       ibus,
   output logic [ADDR_WIDTH-1:0] if_pc_o,
   output logic [DATA_WIDTH-1:0] if_inst_o,
   output logic                  if_valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;

   logic                  consume;
   logic                  ack;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  unused_inputs;

   assign consume       = !stall_i[1];
   assign ack           = ibus.ibus_ack_i;
   assign jump_target   = {new_pc_i[ADDR_WIDTH-1:2], 2'b00};
   assign pc_inc        = pc_q + ADDR_WIDTH'(4);
   assign unused_inputs = ^{stall_i[5:2], stall_i[0], new_pc_i[1:0]};

   // The address is always the registered PC, so it cannot move while a request waits for ack.
   assign ibus.ibus_addr_o = pc_q;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      redirect_d      = redirect_q;
      buf_d           = buf_q;
      ibus.ibus_req_o = 1'b0;
      if_valid_o      = 1'b0;
      if_inst_o       = NOP_INST;
      if_pc_o         = pc_q;

      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (flush_jump_i) pc_d = jump_target;
         end

         FETCH: begin
            ibus.ibus_req_o = 1'b1;
            if (flush_jump_i) begin
               // A request already on the bus cannot be withdrawn; park the target until it drains.
               if (ack) pc_d = jump_target;
               else begin
                  redirect_d = jump_target;
                  state_d    = DRAIN;
               end
            end else if (ack) begin
               if_valid_o = 1'b1;
               if_inst_o  = ibus.ibus_rdata_i;
               if (consume) pc_d = pc_inc;
               else begin
                  buf_d   = ibus.ibus_rdata_i;
                  state_d = HOLD;
               end
            end
         end

         HOLD: begin
            if (flush_jump_i) begin
               pc_d    = jump_target;
               state_d = FETCH;
            end else begin
               if_valid_o = 1'b1;
               if_inst_o  = buf_q;
               if (consume) begin
                  pc_d    = pc_inc;
                  state_d = FETCH;
               end
            end
         end

         DRAIN: begin
            ibus.ibus_req_o = 1'b1;
            if (ack) begin
               pc_d    = flush_jump_i ? jump_target : redirect_q;
               state_d = FETCH;
            end else if (flush_jump_i) begin
               redirect_d = jump_target;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         redirect_q <= RESET_PC;
         buf_q      <= NOP_INST;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a cycle-exact vector table, hand-written reset/wrap sequence, and
// randomized traffic checked against a program-order instruction-stream model.
module tb_if_fetch_unit;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [5:0]  HOLD_ST  = 6'b000111;
   localparam int          N_RANDOM = 3000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] if_pc, if_inst;
   logic        if_valid;

   if_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ibus ();

   if_fetch_unit dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .stall_i      (stall),
      .flush_jump_i (flush),
      .new_pc_i     (new_pc),
      .ibus         (ibus),
      .if_pc_o      (if_pc),
      .if_inst_o    (if_inst),
      .if_valid_o   (if_valid)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Instruction memory contents: a distinct word per address, never equal to the NOP.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001 | 32'h8000_0000;
   endfunction

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] npc;
      logic        ack;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [5:0] s, input logic f, input logic [31:0] np, input logic a,
                      input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.flush = f; v.npc = np; v.ack = a;
      v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [5:0] s, input logic f, input logic [31:0] np,
                        input logic a, input logic [31:0] rd);
      @(negedge clk);
      stall = s; flush = f; new_pc = np;
      ibus.ibus_ack_i   = a;
      ibus.ibus_rdata_i = rd;
      #2;
   endtask

   logic [31:0] exp_pc;
   logic        pend;
   logic [31:0] pend_addr;
   int          idle;

   initial begin
      rst_n = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
      ibus.ibus_ack_i = 1'b0; ibus.ibus_rdata_i = '0;

      #2;
      check("reset_req",   32'(ibus.ibus_req_o), 32'd0);
      check("reset_valid", 32'(if_valid), 32'd0);
      check("reset_inst",  if_inst, NOP);
      check("reset_pc",    if_pc, 32'h0);

      //  stall     flush npc           ack  req addr          valid pc
      add(6'd0,     0, 32'h0,          0,   0, 32'h0,         0, 32'h0);   // IDLE
      add(6'b111101,0, 32'h0,          1,   1, 32'h0,         1, 32'h0);   // ignored stall bits
      add(6'd0,     0, 32'h0,          1,   1, 32'h4,         1, 32'h4);
      add(HOLD_ST,  0, 32'h0,          1,   1, 32'h8,         1, 32'h8);   // -> HOLD
      add(HOLD_ST,  0, 32'h0,          0,   0, 32'h0,         1, 32'h8);
      add(HOLD_ST,  0, 32'h0,          0,   0, 32'h0,         1, 32'h8);
      add(6'd0,     0, 32'h0,          0,   0, 32'h0,         1, 32'h8);   // consumed
      add(6'd0,     0, 32'h0,          1,   1, 32'hC,         1, 32'hC);
      add(6'd0,     0, 32'h0,          0,   1, 32'h10,        0, 32'h0);   // wait state
      add(6'd0,     0, 32'h0,          0,   1, 32'h10,        0, 32'h0);
      add(6'd0,     0, 32'h0,          1,   1, 32'h10,        1, 32'h10);
      add(6'd0,     0, 32'h0,          1,   1, 32'h14,        1, 32'h14);
      add(6'd0,     0, 32'h0,          1,   1, 32'h18,        1, 32'h18);
      add(6'd0,     0, 32'h0,          1,   1, 32'h1C,        1, 32'h1C);
      add(6'd0,     1, 32'h103,        0,   1, 32'h20,        0, 32'h0);   // jump while pending
      add(6'd0,     0, 32'h0,          0,   1, 32'h20,        0, 32'h0);   // DRAIN holds addr
      add(6'd0,     0, 32'h0,          1,   1, 32'h20,        0, 32'h0);   // drained, dropped
      add(6'd0,     1, 32'h1F0,        0,   1, 32'h100,       0, 32'h0);
      add(HOLD_ST,  1, 32'h200,        0,   1, 32'h100,       0, 32'h0);   // newest target wins
      add(6'd0,     0, 32'h0,          1,   1, 32'h100,       0, 32'h0);
      add(6'd0,     1, 32'h301,        1,   1, 32'h200,       0, 32'h0);   // flush with ack
      add(6'd0,     0, 32'h0,          1,   1, 32'h300,       1, 32'h300);
      add(6'd0,     1, 32'h400,        0,   1, 32'h304,       0, 32'h0);
      add(6'd0,     1, 32'h501,        1,   1, 32'h304,       0, 32'h0);   // DRAIN ack + flush
      add(6'd0,     0, 32'h0,          1,   1, 32'h500,       1, 32'h500);
      add(HOLD_ST,  0, 32'h0,          1,   1, 32'h504,       1, 32'h504); // -> HOLD
      add(HOLD_ST,  1, 32'h600,        0,   0, 32'h0,         0, 32'h0);   // flush drops buffer
      add(6'd0,     0, 32'h0,          1,   1, 32'h600,       1, 32'h600);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         if (i != 0) @(negedge clk);
         stall = tbl[i].stall; flush = tbl[i].flush; new_pc = tbl[i].npc;
         ibus.ibus_ack_i   = tbl[i].ack;
         ibus.ibus_rdata_i = tbl[i].ack ? mem(tbl[i].eaddr) : 32'hDEAD_0000;
         #2;
         check($sformatf("vec%0d_req", i), 32'(ibus.ibus_req_o), 32'(tbl[i].ereq));
         if (tbl[i].ereq) check($sformatf("vec%0d_addr", i), ibus.ibus_addr_o, tbl[i].eaddr);
         check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].evalid));
         check($sformatf("vec%0d_inst", i), if_inst, tbl[i].evalid ? mem(tbl[i].epc) : NOP);
         if (tbl[i].evalid) check($sformatf("vec%0d_pc", i), if_pc, tbl[i].epc);
      end

      // PC wrap at the top of the address space, then asynchronous reset during a wait state.
      drive(6'd0, 1'b1, 32'hFFFF_FFFE, 1'b1, mem(32'h604));
      check("wrap_jump_valid", 32'(if_valid), 32'd0);
      drive(6'd0, 1'b0, 32'h0, 1'b1, mem(32'hFFFF_FFFC));
      check("wrap_top_addr", ibus.ibus_addr_o, 32'hFFFF_FFFC);
      check("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_top_inst", if_inst, mem(32'hFFFF_FFFC));
      drive(6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("wrap_req", 32'(ibus.ibus_req_o), 32'd1);
      check("wrap_addr", ibus.ibus_addr_o, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(ibus.ibus_req_o), 32'd0);
      check("midrst_valid", 32'(if_valid), 32'd0);
      check("midrst_inst", if_inst, NOP);
      check("midrst_pc", if_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("restart_idle_req", 32'(ibus.ibus_req_o), 32'd0);
      drive(6'd0, 1'b0, 32'h0, 1'b1, mem(32'h0));
      check("restart_addr", ibus.ibus_addr_o, 32'h0);
      check("restart_valid", 32'(if_valid), 32'd1);
      check("restart_inst", if_inst, mem(32'h0));

      // Random traffic: delivered instructions must follow program order, restarting at each jump.
      @(negedge clk);
      rst_n = 1'b0;
      ibus.ibus_ack_i = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 32'h0;
      pend   = 1'b0;
      pend_addr = '0;
      idle   = 0;
      for (int i = 0; i < N_RANDOM; i++) begin
         if (i != 0) @(negedge clk);
         stall    = 6'($urandom);
         stall[1] = ($urandom_range(0, 9) < 3);
         flush    = ($urandom_range(0, 19) == 0);
         new_pc   = $urandom;
         #1;
         ibus.ibus_ack_i   = ibus.ibus_req_o && ($urandom_range(0, 2) != 0);
         ibus.ibus_rdata_i = ibus.ibus_ack_i ? mem(ibus.ibus_addr_o) : $urandom;
         #1;
         if (pend) begin
            check("rnd_req_held", 32'(ibus.ibus_req_o), 32'd1);
            check("rnd_addr_held", ibus.ibus_addr_o, pend_addr);
         end
         if (flush) check("rnd_flush_valid", 32'(if_valid), 32'd0);
         if (if_valid) begin
            check("rnd_pc", if_pc, exp_pc);
            check("rnd_inst", if_inst, mem(exp_pc));
         end else begin
            check("rnd_nop", if_inst, NOP);
         end
         pend      = ibus.ibus_req_o && !ibus.ibus_ack_i;
         pend_addr = ibus.ibus_addr_o;
         if (flush) begin
            exp_pc = {new_pc[31:2], 2'b00};
            idle   = 0;
         end else if (if_valid && !stall[1]) begin
            exp_pc = exp_pc + 32'd4;
            idle   = 0;
         end else begin
            idle++;
            if (idle > 100) begin
               check("rnd_progress_timeout", 32'(idle), 32'd0);
               idle = 0;
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
